// File: rtl/screen_flow_controller.sv
// Game flow FSM: start/restart sequencing, win/lose, best score, final pixel.
// Optional: define SCREEN_FLOW_AUTO_RETURN_EN to leave WIN/LOSE on a timeout.
module screen_flow_controller #(
  parameter int WIN_SCORE = 9,
  parameter int GUARD_FRAMES = 4,
  parameter int END_HOLD_FRAMES = 60,
`ifdef SCREEN_FLOW_AUTO_RETURN_EN
  parameter int END_TIMEOUT_FRAMES = 600,
`endif
  parameter int BLINK_FRAMES = 16,
  parameter logic [7:0] BLINK_RGB = 8'hFF
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       key5IsPressed,
  input  logic [3:0] life,
  input  logic [3:0] score,
  input  logic [7:0] RGB_screen_main,
  input  logic [7:0] RGB_screen_start,
  input  logic [7:0] RGB_screen_end,
  output logic       start,
  output logic [7:0] RGB_out,
  output logic [1:0] screenState,
  output logic       gameWon,
  output logic [3:0] bestScore
);

  typedef enum logic [1:0] {
    START = 2'b00,
    PLAY  = 2'b01,
    WIN   = 2'b10,
    LOSE  = 2'b11
  } state_t;

  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [9:0] GUARD_CNT = 10'(GUARD_FRAMES);
  localparam logic [9:0] HOLD_CNT = 10'(END_HOLD_FRAMES);
  localparam logic [3:0] WIN_CNT = 4'(WIN_SCORE);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
`ifdef SCREEN_FLOW_AUTO_RETURN_EN
  localparam logic [9:0] TIMEOUT_CNT = 10'(END_TIMEOUT_FRAMES);
`endif

  state_t state, nextState;
  logic key5D;
  logic rise;
  logic [9:0] frameCnt;
  logic [BW-1:0] blinkCnt;
  logic blink;
  logic endState;
  logic changing;
  logic [7:0] pixNext;

  assign rise = key5IsPressed & ~key5D;
  assign endState = (state == WIN) || (state == LOSE);
  assign changing = (nextState != state);
  assign screenState = state;
  assign gameWon = (state == WIN);

  always_comb begin
    nextState = state;
    unique case (state)
      START: if (rise) nextState = PLAY;
      PLAY: begin
        // LOSE takes priority when both end conditions coincide
        if (frameCnt >= GUARD_CNT) begin
          if (life == 4'd0) nextState = LOSE;
          else if (score >= WIN_CNT) nextState = WIN;
        end
      end
      default: begin
        if (rise && frameCnt >= HOLD_CNT) nextState = START;
`ifdef SCREEN_FLOW_AUTO_RETURN_EN
        if (frameCnt >= TIMEOUT_CNT) nextState = START;
`endif
      end
    endcase
  end

  always_comb begin
    pixNext = 8'h00;
    unique case (1'b1)
      state == START: pixNext = RGB_screen_start;
      state == PLAY:  pixNext = RGB_screen_main;
      endState: begin
        if (blink && RGB_screen_end != 8'h00) pixNext = BLINK_RGB;
        else pixNext = RGB_screen_end;
      end
      default: pixNext = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= START;
      key5D <= 1'b0;
      start <= 1'b0;
      RGB_out <= 8'h00;
      bestScore <= 4'd0;
    end else begin
      state <= nextState;
      key5D <= key5IsPressed;
      start <= (state == START) && rise;
      RGB_out <= pixNext;
      if (state == PLAY && changing && score > bestScore)
        bestScore <= score;
    end
  end

  // A frame pulse on a transition edge is absorbed by the clear
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frameCnt <= 10'd0;
    end else if (changing || state == START) begin
      frameCnt <= 10'd0;
    end else if (startOfFrame) begin
      if (state == PLAY) begin
        if (frameCnt < GUARD_CNT) frameCnt <= frameCnt + 10'd1;
      end else if (frameCnt != 10'h3FF) begin
        frameCnt <= frameCnt + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      blinkCnt <= '0;
      blink <= 1'b0;
    end else if (changing || !endState) begin
      blinkCnt <= '0;
      blink <= 1'b0;
    end else if (startOfFrame) begin
      if (blinkCnt == BLINK_LAST) begin
        blinkCnt <= '0;
        blink <= ~blink;
      end else begin
        blinkCnt <= blinkCnt + BW'(1);
      end
    end
  end

endmodule

// File: doc/screen_flow_controller.md
Name: screen_flow_controller

Overview:
- Top-level game-flow stage that wraps the main play screen.
- Upstream role: owns the start/restart sequence and issues the one-cycle start pulse into the main screen.
- Downstream role: consumes the main screen's life, score and RGB outputs, decides win/lose, tracks best score, and drives the final registered VGA pixel by selecting the start, main or end screen.

Parameters:
- WIN_SCORE, 9, score value (0..15) at or above which PLAY ends in WIN.
- GUARD_FRAMES, 4, frames after entering PLAY during which life/score are ignored while the level resets.
- END_HOLD_FRAMES, 60, frames in WIN/LOSE before key5 is accepted.
- END_TIMEOUT_FRAMES, 600, frames in WIN/LOSE before automatic return to START (optional feature only).
- BLINK_FRAMES, 16, half-period in frames of the end-screen blink.
- BLINK_RGB, 8'hFF, colour substituted for the end-screen pixel during the blink-off phase.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per video frame
- key5IsPressed  in  1  level, start/restart key
- life  in  4  remaining lives from main screen
- score  in  4  score from main screen
- RGB_screen_main  in  8  main screen pixel
- RGB_screen_start  in  8  start screen pixel
- RGB_screen_end  in  8  end screen pixel (win/lose art selected externally by gameWon)
- start  out  1  one-cycle pulse, begins a new game in main screen
- RGB_out  out  8  final pixel, registered
- screenState  out  2  00 START, 01 PLAY, 10 WIN, 11 LOSE
- gameWon  out  1  1 in WIN, 0 otherwise
- bestScore  out  4  highest final score since reset

Behaviour:
- Reset (async, resetN=0):
  - state=START, start=0, RGB_out=0, gameWon=0, bestScore=0.
  - All frame counters=0, key edge register=0, blink phase=0.
- Key edge: key5 registered each clk; rise = key5IsPressed & ~key5_d. Level hold never retriggers.
- START:
  - On rise: next state PLAY, start=1 for exactly the next cycle.
  - Frame counter cleared.
- PLAY:
  - Frame counter increments on startOfFrame, saturating at GUARD_FRAMES.
  - While counter < GUARD_FRAMES, life/score are ignored.
  - After the guard: life==0 goes to LOSE; otherwise score>=WIN_SCORE goes to WIN.
  - If both conditions hold in the same cycle, LOSE wins.
  - Key rises in PLAY are ignored; key5 belongs to the spring.
- Entering WIN/LOSE:
  - Same cycle: bestScore <= max(bestScore, score). Frame counter and blink phase cleared.
  - gameWon=1 only in WIN.
- WIN/LOSE:
  - Frame counter increments on startOfFrame, saturating at its maximum (10 bits).
  - A rise with counter >= END_HOLD_FRAMES goes to START. A rise before that is dropped, not queued.
  - Blink phase toggles every BLINK_FRAMES frames.
- Pixel path, one-cycle latency from the RGB inputs to RGB_out:
  - START: RGB_screen_start.
  - PLAY: RGB_screen_main.
  - WIN/LOSE, phase 0: RGB_screen_end.
  - WIN/LOSE, phase 1: BLINK_RGB where RGB_screen_end != 8'h00, else 8'h00.
- screenState and gameWon are registered and change in the same cycle as the state register.
- A startOfFrame coinciding with a state transition is counted in the new state from zero: the counter is cleared, not incremented.
- Reset mid-game: immediate return to START. bestScore clears. No start pulse is generated.

Optional Feature:
- Macro: SCREEN_FLOW_AUTO_RETURN_EN.
- Defined: in WIN/LOSE, when the frame counter reaches END_TIMEOUT_FRAMES, go to START without a key press. bestScore is retained.
- Undefined: WIN/LOSE is left only by a key5 rise after END_HOLD_FRAMES. END_TIMEOUT_FRAMES is unused.

Test Plan:
- Reset, then hold key5 high for 100 cycles -> exactly one start pulse one cycle after the rise; screenState=01; RGB_out follows RGB_screen_main with 1-cycle delay.
- PLAY with life=0 in frames 1-3, then life=2 -> no LOSE (guard); life=0 at frame 5 -> screenState=11, gameWon=0.
- After the guard, set life=0 and score=9 in the same cycle -> LOSE, bestScore=9.
- WIN with score=10, then key5 rise at frame 30 -> stays WIN; rise at frame 61 -> START, no start pulse; bestScore=10; a later game ending at score=3 leaves bestScore=10.
- In WIN, RGB_screen_end=8'h1C -> RGB_out=8'h1C for frames 0-15, 8'hFF for frames 16-31; RGB_screen_end=8'h00 -> RGB_out=8'h00 throughout.
- With SCREEN_FLOW_AUTO_RETURN_EN defined, idle in LOSE -> START at frame 600. Undefined -> still LOSE at frame 1000. In both cases, resetN low mid-PLAY -> START and RGB_out=0 asynchronously.
